// File: rtl/game_state_ctrl_pkg.sv
// rtl/game_state_ctrl_pkg.sv - game flow state encodings and default lives/level/frame constants
package game_state_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SPAWN       = 3'd1,
    ST_RUNNING     = 3'd2,
    ST_DYING       = 3'd3,
    ST_LEVEL_CLEAR = 3'd4,
    ST_GAME_OVER   = 3'd5,
    ST_PAUSED      = 3'd6
  } game_state_t;

  localparam int DEF_NUM_LIVES    = 3;
  localparam int DEF_MAX_LEVEL    = 9;
  localparam int DEF_SPAWN_FRAMES = 30;
  localparam int DEF_DEATH_FRAMES = 60;
  localparam int DEF_CLEAR_FRAMES = 45;
  localparam int DEF_FRM_W        = 8;

endpackage

// File: rtl/game_state_ctrl_frame_timer.sv
// rtl/game_state_ctrl_frame_timer.sv - frame_timer: counts frame ticks, synchronous clear wins over tick
module frame_timer #(
  parameter int FRM_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             clear,
  input  logic             tick,
  output logic [FRM_W-1:0] count
);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game flow controller (lives, levels, timed phases);
// define GAME_PAUSE_EN to enable the PAUSED state driven by i_Pause edges.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int NUM_LIVES    = DEF_NUM_LIVES,
  parameter int MAX_LEVEL    = DEF_MAX_LEVEL,
  parameter int SPAWN_FRAMES = DEF_SPAWN_FRAMES,
  parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
  parameter int CLEAR_FRAMES = DEF_CLEAR_FRAMES,
  parameter int FRM_W        = DEF_FRM_W,
  localparam int LIVES_W     = $clog2(NUM_LIVES + 1),
  localparam int LEVEL_W     = $clog2(MAX_LEVEL + 1)
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Frame_Tick,
  input  logic               i_Start,
  input  logic               i_Pause,
  input  logic               i_Collision,
  input  logic               i_Level_Up,
  output logic               o_Game_Active,
  output logic               o_Frog_Reset,
  output logic [LIVES_W-1:0] o_Lives,
  output logic [LEVEL_W-1:0] o_Level,
  output logic               o_Game_Over,
  output logic [2:0]         o_State
);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
  localparam logic [FRM_W-1:0]   SPAWN_N    = FRM_W'(SPAWN_FRAMES);
  localparam logic [FRM_W-1:0]   DEATH_N    = FRM_W'(DEATH_FRAMES);
  localparam logic [FRM_W-1:0]   CLEAR_N    = FRM_W'(CLEAR_FRAMES);

  game_state_t      state;
  logic             start_q;
  logic             start_edge;
  logic             pause_edge;
  logic [FRM_W-1:0] frm_count;
  logic             timed_phase;
  logic             phase_done;
  logic             timer_clr;

  assign o_State = state;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      start_q <= 1'b0;
    end else begin
      start_q <= i_Start;
    end
  end
  assign start_edge = i_Start & ~start_q;

`ifdef GAME_PAUSE_EN
  logic pause_q;
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pause_q <= 1'b0;
    end else begin
      pause_q <= i_Pause;
    end
  end
  assign pause_edge = i_Pause & ~pause_q;
`else
  logic unused_pause;
  assign unused_pause = i_Pause;
  assign pause_edge   = 1'b0;
`endif

  // Timer is held at zero outside timed phases, so entry from those states starts at 0.
  assign timed_phase = (state == ST_SPAWN) || (state == ST_DYING) || (state == ST_LEVEL_CLEAR);

  always_comb begin
    phase_done = 1'b0;
    case (state)
      ST_SPAWN:       phase_done = (frm_count == SPAWN_N);
      ST_DYING:       phase_done = (frm_count == DEATH_N);
      ST_LEVEL_CLEAR: phase_done = (frm_count == CLEAR_N);
      default:        phase_done = 1'b0;
    endcase
  end

  assign timer_clr = ~timed_phase | phase_done;

  frame_timer #(
    .FRM_W (FRM_W)
  ) u_frame_timer (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .clear   (timer_clr),
    .tick    (i_Frame_Tick),
    .count   (frm_count)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= ST_IDLE;
      o_Lives       <= LIVES_INIT;
      o_Level       <= '0;
      o_Game_Active <= 1'b0;
      o_Frog_Reset  <= 1'b0;
      o_Game_Over   <= 1'b0;
    end else begin
      o_Frog_Reset <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            state        <= ST_SPAWN;
            o_Lives      <= LIVES_INIT;
            o_Level      <= '0;
            o_Frog_Reset <= 1'b1;
          end
        end
        ST_SPAWN: begin
          if (phase_done) begin
            state         <= ST_RUNNING;
            o_Game_Active <= 1'b1;
          end
        end
        ST_RUNNING: begin
          // Collision outranks level-up, which outranks pause.
          if (i_Collision) begin
            state         <= ST_DYING;
            o_Lives       <= o_Lives - 1'b1;
            o_Game_Active <= 1'b0;
          end else if (i_Level_Up) begin
            state         <= ST_LEVEL_CLEAR;
            o_Game_Active <= 1'b0;
            if (o_Level != LEVEL_MAX) begin
              o_Level <= o_Level + 1'b1;
            end
          end else if (pause_edge) begin
            state         <= ST_PAUSED;
            o_Game_Active <= 1'b0;
          end
        end
        ST_DYING: begin
          if (phase_done) begin
            if (o_Lives == '0) begin
              state       <= ST_GAME_OVER;
              o_Game_Over <= 1'b1;
            end else begin
              state        <= ST_SPAWN;
              o_Frog_Reset <= 1'b1;
            end
          end
        end
        ST_LEVEL_CLEAR: begin
          if (phase_done) begin
            state        <= ST_SPAWN;
            o_Frog_Reset <= 1'b1;
          end
        end
        ST_GAME_OVER: begin
          if (start_edge) begin
            state       <= ST_IDLE;
            o_Game_Over <= 1'b0;
          end
        end
        ST_PAUSED: begin
          if (pause_edge) begin
            state         <= ST_RUNNING;
            o_Game_Active <= 1'b1;
          end
        end
        default: begin
          state         <= ST_IDLE;
          o_Game_Active <= 1'b0;
          o_Game_Over   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - scoreboard bench for game_state_ctrl with a phase-countdown reference model
module tb_game_state_ctrl;

  localparam int NL = 3;
  localparam int ML = 9;
  localparam int SP = 30;
  localparam int DT = 60;
  localparam int CL = 45;

  localparam int S_IDLE   = 0;
  localparam int S_SPAWN  = 1;
  localparam int S_RUN    = 2;
  localparam int S_DYING  = 3;
  localparam int S_CLEAR  = 4;
  localparam int S_OVER   = 5;
  localparam int S_PAUSED = 6;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Frame_Tick = 1'b0;
  logic       i_Start = 1'b0;
  logic       i_Pause = 1'b0;
  logic       i_Collision = 1'b0;
  logic       i_Level_Up = 1'b0;
  logic       o_Game_Active;
  logic       o_Frog_Reset;
  logic [1:0] o_Lives;
  logic [3:0] o_Level;
  logic       o_Game_Over;
  logic [2:0] o_State;

  always #5 i_Clk = ~i_Clk;

  game_state_ctrl #(
    .NUM_LIVES    (NL),
    .MAX_LEVEL    (ML),
    .SPAWN_FRAMES (SP),
    .DEATH_FRAMES (DT),
    .CLEAR_FRAMES (CL),
    .FRM_W        (8)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Rst_L       (i_Rst_L),
    .i_Frame_Tick  (i_Frame_Tick),
    .i_Start       (i_Start),
    .i_Pause       (i_Pause),
    .i_Collision   (i_Collision),
    .i_Level_Up    (i_Level_Up),
    .o_Game_Active (o_Game_Active),
    .o_Frog_Reset  (o_Frog_Reset),
    .o_Lives       (o_Lives),
    .o_Level       (o_Level),
    .o_Game_Over   (o_Game_Over),
    .o_State       (o_State)
  );

  typedef struct {
    int st;
    int lives;
    int level;
    int act;
    int frog;
    int over;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Reference model: each timed phase holds a countdown of remaining frame ticks.
  int m_st, m_lives, m_level, m_left, m_frog;
  bit m_prev_start, m_prev_pause;

  function automatic int phase_len(int s);
    case (s)
      S_SPAWN: return SP;
      S_DYING: return DT;
      S_CLEAR: return CL;
      default: return 0;
    endcase
  endfunction

  function automatic void enter(int s);
    m_st   = s;
    m_left = phase_len(s);
  endfunction

  function automatic void m_reset();
    m_st = S_IDLE; m_lives = NL; m_level = 0; m_left = 0; m_frog = 0;
    m_prev_start = 1'b0; m_prev_pause = 1'b0;
  endfunction

  function automatic void m_step(bit start, bit pause, bit col, bit lvl, bit tick);
    bit se, pe;
    se = start && !m_prev_start;
    m_prev_start = start;
    pe = pause && !m_prev_pause;
    m_prev_pause = pause;
`ifndef GAME_PAUSE_EN
    pe = 1'b0;
`endif
    m_frog = 0;
    if (m_st == S_SPAWN || m_st == S_DYING || m_st == S_CLEAR) begin
      if (m_left == 0) begin
        if (m_st == S_SPAWN) enter(S_RUN);
        else if (m_st == S_DYING && m_lives == 0) enter(S_OVER);
        else begin
          enter(S_SPAWN);
          m_frog = 1;
        end
      end else if (tick) begin
        m_left = m_left - 1;
      end
    end else begin
      case (m_st)
        S_IDLE: if (se) begin
          enter(S_SPAWN); m_lives = NL; m_level = 0; m_frog = 1;
        end
        S_RUN: begin
          if (col) begin
            m_lives = m_lives - 1; enter(S_DYING);
          end else if (lvl) begin
            if (m_level < ML) m_level = m_level + 1;
            enter(S_CLEAR);
          end else if (pe) begin
            enter(S_PAUSED);
          end
        end
        S_OVER:   if (se) enter(S_IDLE);
        S_PAUSED: if (pe) enter(S_RUN);
        default: ;
      endcase
    end
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  // Drive one cycle of inputs and push the outputs expected after the next edge.
  task automatic step(bit start, bit pause, bit col, bit lvl, bit tick);
    exp_t e;
    @(posedge i_Clk);
    #2;
    i_Start = start; i_Pause = pause; i_Collision = col; i_Level_Up = lvl; i_Frame_Tick = tick;
    m_step(start, pause, col, lvl, tick);
    e.st = m_st; e.lives = m_lives; e.level = m_level;
    e.act = (m_st == S_RUN) ? 1 : 0;
    e.frog = m_frog;
    e.over = (m_st == S_OVER) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic wait_model(int s, bit start);
    int n;
    n = 0;
    while (m_st != s && n < 300) begin
      step(start, 1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    if (m_st != s) begin
      checks++;
      errors++;
      $display("FAIL wait_state cyc=%0d got=%0d expected=%0d", cyc, m_st, s);
    end
  endtask

  task automatic async_reset();
    @(posedge i_Clk);
    #3;
    i_Rst_L = 1'b0;
    i_Start = 1'b0; i_Pause = 1'b0; i_Collision = 1'b0; i_Level_Up = 1'b0; i_Frame_Tick = 1'b0;
    #1;
    chk("arst_state", o_State, S_IDLE);
    chk("arst_lives", o_Lives, NL);
    chk("arst_level", o_Level, 0);
    chk("arst_active", o_Game_Active, 0);
    chk("arst_frog", o_Frog_Reset, 0);
    chk("arst_over", o_Game_Over, 0);
    m_reset();
    @(posedge i_Clk);
    #2;
    i_Rst_L = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge i_Clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state", o_State, e.st);
        chk("lives", o_Lives, e.lives);
        chk("level", o_Level, e.level);
        chk("active", o_Game_Active, e.act);
        chk("frog_reset", o_Frog_Reset, e.frog);
        chk("game_over", o_Game_Over, e.over);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit rs, rp, rc, rl, rt;
    m_reset();
    repeat (2) @(posedge i_Clk);
    #1;
    chk("rst_state", o_State, S_IDLE);
    chk("rst_lives", o_Lives, NL);
    chk("rst_level", o_Level, 0);
    chk("rst_active", o_Game_Active, 0);
    chk("rst_over", o_Game_Over, 0);
    chk("rst_frog", o_Frog_Reset, 0);
    #1;
    i_Rst_L = 1'b1;

    // Start held high from reset; collisions during SPAWN must be ignored.
    for (int k = 0; k < 40; k++) step(1'b1, 1'b0, (k >= 5 && k <= 10), 1'b0, 1'b1);

    // One death and respawn.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_model(S_SPAWN, 1'b1);
    wait_model(S_RUN, 1'b1);

    // Ten level-ups saturate the level.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_model(S_RUN, 1'b1);
    end

    // Collision with level-up on the same edge, then the final death.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_model(S_RUN, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_model(S_OVER, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of DYING.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_model(S_RUN, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    async_reset();

    // Pause edges in RUNNING with a collision and level-up while (possibly) paused.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_model(S_RUN, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    rs = 1'b1;
    rp = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) rs = ~rs;
      if ($urandom_range(0, 19) == 0) rp = ~rp;
      rc = ($urandom_range(0, 24) == 0);
      rl = ($urandom_range(0, 24) == 0);
      rt = ($urandom_range(0, 9) < 7);
      step(rs, rp, rc, rl, rt);
    end

    repeat (3) @(posedge i_Clk);
    #2;
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
